dma_rr_arbiter: RTL and testbench
=================================

Name: dma_rr_arbiter

Overview:
- Parametrised N-channel DMA bus arbiter.
- Grants one DMA engine at a time (TX, RX, memory-copy, ...) ownership of the shared system bus.
- Multiplexes the owner's Address/Cs/Bus_req onto the bus.
- Adds round-robin fairness, a configurable idle park channel and a one-cycle bus turnaround between owners.

Parameters:
- NUM_CH, 2, number of requesting channels (>=2).
- ADDR_W, 8, bus address width.
- PARK_CH, 0, channel whose Enable stays high while the arbiter is idle.
- TIMEOUT_CYC, 255, max grant length in cycles; used only with the optional feature.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous reset, active-high.
- Req  in  NUM_CH  per-channel level request: start/pending.
- Done  in  NUM_CH  per-channel end-of-transfer pulse.
- Address_ch  in  NUM_CH*ADDR_W  packed per-channel addresses; channel i at [i*ADDR_W +: ADDR_W].
- Cs_ch  in  NUM_CH  per-channel chip select.
- Bus_req_ch  in  NUM_CH  per-channel bus request.
- Enable  out  NUM_CH  one-hot channel enable; all-zero allowed.
- Address  out  ADDR_W  muxed bus address.
- Cs  out  1  muxed chip select.
- Bus_req  out  1  muxed bus request.
- Owner  out  CH_W  index of current owner; CH_W = max(1,$clog2(NUM_CH)).
- Busy  out  1  high in GRANT state.
- Timeout  out  1  one-cycle pulse on a forced release.

Behaviour:
- All state registers, and therefore every registered output, update on posedge Clk.
- Reset (synchronous, Rst=1):
  - State = IDLE, Owner = 0, rr pointer = NUM_CH-1 (so channel 0 has first priority).
  - Enable = one-hot(PARK_CH); Address = 0, Cs = 0, Bus_req = 0, Busy = 0, Timeout = 0.
  - Reset mid-transfer aborts the grant immediately, with no RELEASE cycle.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - Enable = one-hot(PARK_CH); bus outputs = 0.
  - If Req != 0: pick the winner, Owner <= winner, go to GRANT.
  - Done is ignored in IDLE.
- Pick rule:
  - Scan indices pointer+1, pointer+2, ... modulo NUM_CH; the first index with Req set wins.
  - Wrap from NUM_CH-1 to 0 is required.
- GRANT:
  - Enable = one-hot(Owner); Address/Cs/Bus_req driven combinationally from channel Owner; Busy = 1.
  - Done[Owner] = 1 -> go to RELEASE.
  - Done or Req from any other channel is ignored.
  - Owner's Req dropping without Done does not release the grant.
- RELEASE:
  - Exactly one cycle. Enable = 0, bus outputs = 0, Busy = 0.
  - pointer <= Owner; go to IDLE.
- Latency:
  - Req sampled high in IDLE at edge n -> GRANT outputs valid after edge n+1.
  - Done[Owner] at edge m -> RELEASE after m+1 -> IDLE after m+2.
  - Back-to-back minimum: grant, then 1 RELEASE cycle, then 1 IDLE cycle, then next grant.
- Simultaneous Req from several channels: round-robin pick as above.
- A lone requester is re-granted repeatedly.
- Done[Owner] in the same cycle the grant is entered is not possible: Done is sampled only in GRANT.
- Enable is never multi-hot.

Optional Feature:
- Macro: DMA_ARB_TIMEOUT_EN.
- Defined:
  - Cycle counter of width $clog2(TIMEOUT_CYC+1), cleared on entering GRANT and incremented each GRANT cycle.
  - When the count reaches TIMEOUT_CYC without Done[Owner]: force RELEASE and pulse Timeout for that same transition cycle.
  - Done[Owner] on the limit cycle takes precedence, so no Timeout.
- Undefined:
  - No counter is built; Timeout is tied 0; grants are unbounded.

Decomposition:
- Package dma_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, GRANT, RELEASE}.
  - localparam function clog2_min1.
- Sub-module dma_rr_picker:
  - Combinational; inputs Req and pointer; outputs winner index and a valid flag.
  - Parametrised by NUM_CH; verified standalone.

Test Plan:
- Reset then idle, NUM_CH=4, PARK_CH=0 -> Enable=4'b0001, Address=0, Cs=0, Bus_req=0, Busy=0.
- Req=4'b0100, Address_ch[2]=8'h5A, Cs_ch[2]=1, Bus_req_ch[2]=1 -> next cycle Enable=4'b0100, Owner=2, Address=8'h5A, Cs=1, Bus_req=1; Done[2] -> RELEASE (Enable=0) -> IDLE.
- Req=4'b1111 held with each grant ended by Done -> grant order 0,1,2,3,0 (wrap), with one all-zero Enable cycle between grants.
- During grant to ch1, pulse Done[3] and drop Req[1] -> grant held on ch1 until Done[1].
- Rst=1 while Owner=3 in GRANT -> next edge IDLE, Enable=4'b0001; next Req=4'b1000 -> ch3 granted (pointer reset).
- With DMA_ARB_TIMEOUT_EN and TIMEOUT_CYC=4, grant ch0 with no Done:
  - Expected: forced RELEASE after 4 GRANT cycles, Timeout=1 for one cycle.
  - Repeat with Done[0] on the 4th GRANT cycle: normal release, Timeout=0.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the round-robin DMA bus arbiter.
package dma_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/dma_rr_picker.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping modulo NUM_CH.
module dma_rr_picker
   import dma_arb_pkg::*;
#(
   parameter  int unsigned NUM_CH = 2,
   localparam int unsigned CH_W   = clog2_min1(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic [CH_W-1:0]   winner_c_o,
   output logic              valid_c_o
);

   int unsigned idx;

   always_comb begin
      winner_c_o = '0;
      valid_c_o  = 1'b0;
      idx        = 0;
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         idx = (32'(ptr_i) + k) % NUM_CH;
         if (!valid_c_o && req_i[CH_W'(idx)]) begin
            winner_c_o = CH_W'(idx);
            valid_c_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_rr_arbiter.sv
// N-channel DMA bus arbiter with round-robin fairness, idle park channel and turnaround cycle.
// Define DMA_ARB_TIMEOUT_EN to bound each grant to TIMEOUT_CYC cycles.
module dma_rr_arbiter
   import dma_arb_pkg::*;
#(
   parameter  int unsigned NUM_CH      = 2,
   parameter  int unsigned ADDR_W      = 8,
   parameter  int unsigned PARK_CH     = 0,
   parameter  int unsigned TIMEOUT_CYC = 255,
   localparam int unsigned CH_W        = clog2_min1(NUM_CH)
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [NUM_CH-1:0]        Req,
   input  logic [NUM_CH-1:0]        Done,
   input  logic [NUM_CH*ADDR_W-1:0] Address_ch,
   input  logic [NUM_CH-1:0]        Cs_ch,
   input  logic [NUM_CH-1:0]        Bus_req_ch,
   output logic [NUM_CH-1:0]        Enable,
   output logic [ADDR_W-1:0]        Address,
   output logic                     Cs,
   output logic                     Bus_req,
   output logic [CH_W-1:0]          Owner,
   output logic                     Busy,
   output logic                     Timeout
);

   localparam logic [NUM_CH-1:0] PARK_OH = NUM_CH'(1) << PARK_CH;

   if (NUM_CH < 2) begin : g_chk_num_ch
      $error("dma_rr_arbiter: NUM_CH must be >= 2");
   end
   if (PARK_CH >= NUM_CH) begin : g_chk_park
      $error("dma_rr_arbiter: PARK_CH out of range");
   end
   if (TIMEOUT_CYC < 1) begin : g_chk_timeout
      $error("dma_rr_arbiter: TIMEOUT_CYC must be >= 1");
   end

   arb_state_t        state_q;
   logic [CH_W-1:0]   owner_q;
   logic [CH_W-1:0]   ptr_q;
   logic [NUM_CH-1:0] enable_q;
   logic              busy_q;
   logic              timeout_q;

   logic [CH_W-1:0]   pick_idx_c;
   logic              pick_vld_c;
   logic              done_own_c;
   logic              tmo_hit_c;
   logic [ADDR_W-1:0] addr_arr [NUM_CH];

   dma_rr_picker #(.NUM_CH(NUM_CH)) u_picker (
      .req_i      (Req),
      .ptr_i      (ptr_q),
      .winner_c_o (pick_idx_c),
      .valid_c_o  (pick_vld_c)
   );

   for (genvar g = 0; g < NUM_CH; g++) begin : g_addr
      assign addr_arr[g] = Address_ch[g*ADDR_W +: ADDR_W];
   end

   assign done_own_c = Done[owner_q];

`ifdef DMA_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = clog2_min1(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q;

   // Counts completed GRANT cycles; held at zero outside GRANT.
   always_ff @(posedge Clk) begin
      if (Rst || state_q != GRANT) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tmo_hit_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign tmo_hit_c = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= CH_W'(NUM_CH - 1);
         enable_q  <= PARK_OH;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_vld_c) begin
                  state_q  <= GRANT;
                  owner_q  <= pick_idx_c;
                  enable_q <= NUM_CH'(1) << pick_idx_c;
                  busy_q   <= 1'b1;
               end
            end
            GRANT: begin
               // Done on the limit cycle wins, so Timeout only flags a forced release.
               if (done_own_c || tmo_hit_c) begin
                  state_q   <= RELEASE;
                  enable_q  <= '0;
                  busy_q    <= 1'b0;
                  timeout_q <= ~done_own_c;
               end
            end
            RELEASE: begin
               state_q  <= IDLE;
               ptr_q    <= owner_q;
               enable_q <= PARK_OH;
            end
            default: begin
               state_q  <= IDLE;
               enable_q <= PARK_OH;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   // Bus signals follow the owner live while granted, quiet otherwise.
   always_comb begin
      Address = '0;
      Cs      = 1'b0;
      Bus_req = 1'b0;
      if (state_q == GRANT) begin
         Address = addr_arr[owner_q];
         Cs      = Cs_ch[owner_q];
         Bus_req = Bus_req_ch[owner_q];
      end
   end

   assign Enable  = enable_q;
   assign Owner   = owner_q;
   assign Busy    = busy_q;
   assign Timeout = timeout_q;

endmodule

// File: tb/tb_dma_rr_arbiter.sv
// Self-checking bench for dma_rr_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_dma_rr_arbiter;

   localparam int unsigned N    = 4;
   localparam int unsigned AW   = 8;
   localparam int unsigned PARK = 0;
`ifdef DMA_ARB_TIMEOUT_EN
   localparam int unsigned TO   = 4;
`else
   localparam int unsigned TO   = 255;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req, done, cs_ch, breq_ch;
   logic [N*AW-1:0] addr_ch;
   logic [N-1:0]  enable;
   logic [AW-1:0] address;
   logic          cs, bus_req, busy, timeout;
   logic [1:0]    owner;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dma_rr_arbiter #(
      .NUM_CH(N), .ADDR_W(AW), .PARK_CH(PARK), .TIMEOUT_CYC(TO)
   ) dut (
      .Clk(clk), .Rst(rst), .Req(req), .Done(done),
      .Address_ch(addr_ch), .Cs_ch(cs_ch), .Bus_req_ch(breq_ch),
      .Enable(enable), .Address(address), .Cs(cs), .Bus_req(bus_req),
      .Owner(owner), .Busy(busy), .Timeout(timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got 'h%0h expected 'h%0h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = idle (parked), 1 = granted, 2 = turnaround
   int m_phase, m_owner, m_ptr, m_len;
   bit m_to;
   bit model_ok = 1'b0;

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 1; k <= N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase  = 0;
         m_owner  = 0;
         m_ptr    = N - 1;
         m_len    = 0;
         m_to     = 1'b0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         m_to = 1'b0;
         case (m_phase)
            0: if (req != '0) begin
               m_owner = rr_pick(req, m_ptr);
               m_phase = 1;
               m_len   = 0;
            end
            1: begin
               m_len++;
               if (done[m_owner]) m_phase = 2;
`ifdef DMA_ARB_TIMEOUT_EN
               else if (m_len == TO) begin
                  m_phase = 2;
                  m_to    = 1'b1;
               end
`endif
            end
            default: begin
               m_ptr   = m_owner;
               m_phase = 0;
            end
         endcase
      end
   end

   logic [N-1:0]  exp_en;
   logic [AW-1:0] exp_addr;
   logic          exp_cs, exp_breq;

   // Compare every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (model_ok) begin
         exp_en   = (m_phase == 0) ? (N'(1) << PARK) : (m_phase == 1) ? (N'(1) << m_owner) : '0;
         exp_addr = (m_phase == 1) ? addr_ch[m_owner*AW +: AW] : '0;
         exp_cs   = (m_phase == 1) ? cs_ch[m_owner] : 1'b0;
         exp_breq = (m_phase == 1) ? breq_ch[m_owner] : 1'b0;
         check("m_enable",  32'(enable),  32'(exp_en));
         check("m_owner",   32'(owner),   32'(m_owner));
         check("m_address", 32'(address), 32'(exp_addr));
         check("m_cs",      32'(cs),      32'(exp_cs));
         check("m_bus_req", 32'(bus_req), 32'(exp_breq));
         check("m_busy",    32'(busy),    32'(m_phase == 1));
         check("m_timeout", 32'(timeout), 32'(m_to));
         check("m_onehot",  32'($countones(enable) <= 1), 32'd1);
      end
   end

   // ---------------- stimulus with literal pins ----------------
   int exp_order [5] = '{0, 1, 2, 3, 0};

   initial begin
      rst = 1'b1; req = '0; done = '0; addr_ch = '0; cs_ch = '0; breq_ch = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_enable", 32'(enable), 32'h1);
      check("rst_address", 32'(address), 32'h0);
      check("rst_cs", 32'(cs), 32'h0);
      check("rst_bus_req", 32'(bus_req), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_owner", 32'(owner), 32'h0);
      tick();
      check("idle_park", 32'(enable), 32'h1);

      // Single requester on channel 2
      addr_ch[2*AW +: AW] = 8'h5A; cs_ch = 4'b0100; breq_ch = 4'b0100; req = 4'b0100;
      tick();
      check("g2_enable", 32'(enable), 32'b0100);
      check("g2_owner", 32'(owner), 32'd2);
      check("g2_address", 32'(address), 32'h5A);
      check("g2_cs", 32'(cs), 32'h1);
      check("g2_bus_req", 32'(bus_req), 32'h1);
      check("g2_busy", 32'(busy), 32'h1);
      done = 4'b0100; req = '0;
      tick();
      check("g2_rel_enable", 32'(enable), 32'h0);
      check("g2_rel_busy", 32'(busy), 32'h0);
      done = '0;
      tick();
      check("g2_idle_enable", 32'(enable), 32'h1);

      // All requesting: rotation with wrap after a fresh reset
      rst = 1'b1;
      tick();
      rst = 1'b0; req = 4'b1111; cs_ch = 4'b1111; breq_ch = 4'b1010; addr_ch = 32'hD4C3B2A1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_owner", 32'(owner), 32'(exp_order[k]));
         check("rr_enable", 32'(enable), 32'(4'b0001 << exp_order[k]));
         done = 4'b0001 << exp_order[k];
         tick();
         check("rr_gap", 32'(enable), 32'h0);
         done = '0;
         tick();
         check("rr_idle", 32'(enable), 32'h1);
      end
      tick();
      check("hold_owner", 32'(owner), 32'd1);

      // Foreign Done and dropped own Req must not release
      req = 4'b1101; done = 4'b1000;
      tick();
      check("hold_enable", 32'(enable), 32'b0010);
      done = '0;
      tick(); tick();
      check("hold_still", 32'(enable), 32'b0010);
      check("hold_busy", 32'(busy), 32'h1);
      done = 4'b0010; req = '0;
      tick();
      check("hold_rel", 32'(enable), 32'h0);
      done = '0;
      tick();

      // Reset mid-grant aborts and resets the pointer
      req = 4'b1000;
      tick();
      check("abort_owner", 32'(owner), 32'd3);
      rst = 1'b1; req = 4'b1010;
      tick();
      check("abort_enable", 32'(enable), 32'h1);
      check("abort_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      tick();
      check("ptr_reset_owner", 32'(owner), 32'd1);
      done = 4'b0010; req = '0;
      tick();
      done = '0;
      tick();

`ifdef DMA_ARB_TIMEOUT_EN
      req = 4'b0001;
      tick();
      req = '0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("to_busy", 32'(busy), 32'h1);
      end
      tick();
      check("to_pulse", 32'(timeout), 32'h1);
      check("to_rel_enable", 32'(enable), 32'h0);
      tick();
      check("to_pulse_end", 32'(timeout), 32'h0);
      req = 4'b0001;
      tick();
      req = '0;
      tick(); tick(); tick();
      done = 4'b0001;
      tick();
      check("to_done_wins", 32'(timeout), 32'h0);
      check("to_done_rel", 32'(enable), 32'h0);
      done = '0;
      tick();
`else
      req = 4'b0001;
      tick();
      req = '0;
      repeat (300) tick();
      check("unbounded_busy", 32'(busy), 32'h1);
      check("unbounded_timeout", 32'(timeout), 32'h0);
      done = 4'b0001;
      tick();
      done = '0;
      tick();
`endif

      // Randomized traffic, checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         rst     = ($urandom_range(0, 199) == 0);
         req     = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom);
         done    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : '0;
         addr_ch = $urandom;
         cs_ch   = 4'($urandom);
         breq_ch = 4'($urandom);
         tick();
      end
      rst = 1'b0; req = '0; done = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
